// File: rtl/prefix_add_scheduler.sv
// prefix_add_scheduler: round-robin, byte-serial sharing of one 8-bit prefix adder among NREQ requesters (PFX_SCHED_OVF_EN adds rsp_ovf)
module prefix_add_scheduler #(
  parameter int NREQ = 2,
  parameter int NBYTES = 4,
  localparam int W = 8 * NBYTES,
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IW-1:0]     rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_cout,
`ifdef PFX_SCHED_OVF_EN
  output logic              rsp_ovf,
`endif
  output logic [7:0]        add_ai,
  output logic [7:0]        add_bi,
  output logic              add_p_minus1,
  output logic              add_g_minus1,
  input  logic [7:0]        add_sum,
  input  logic              add_cout
);
  localparam int CW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [W-1:0] a_sh, b_sh, result;
  logic [CW-1:0] cnt;
  logic [IW-1:0] rr_ptr, gnt_id, id_q, cand;
  logic carry, cout_q, gnt_found, last, accept;
`ifdef PFX_SCHED_OVF_EN
  logic ovf_q;
  assign rsp_ovf = ovf_q;
`endif
  always_comb begin
    gnt_found = 1'b0;
    gnt_id = '0;
    cand = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IW'((int'(rr_ptr) + i) % NREQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id = cand;
      end
    end
  end
  assign accept = state == IDLE && gnt_found;
  assign last = cnt == CW'(NBYTES - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == IDLE ? (gnt_found ? RUN : IDLE) :
                state == RUN  ? (last ? DONE : RUN) :
                (rsp_ready ? IDLE : DONE);
  end
  always_comb begin
    req_ready = (accept && !reset) ? NREQ'(1) << gnt_id : '0;
    rsp_valid = state == DONE;
    add_ai = state == RUN ? a_sh[7:0] : 8'h00;
    add_bi = state == RUN ? b_sh[7:0] : 8'h00;
    add_g_minus1 = state == RUN ? carry : 1'b0;
    add_p_minus1 = 1'b0;
  end
  assign rsp_sum = result;
  assign rsp_id = id_q;
  assign rsp_cout = cout_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh <= '0;
      b_sh <= '0;
      result <= '0;
      cnt <= '0;
      carry <= 1'b0;
      cout_q <= 1'b0;
      id_q <= '0;
      rr_ptr <= '0;
`ifdef PFX_SCHED_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      if (accept) begin
        a_sh <= req_a[gnt_id*W +: W];
        b_sh <= req_b[gnt_id*W +: W];
        carry <= req_cin[gnt_id];
        id_q <= gnt_id;
        rr_ptr <= gnt_id == IW'(NREQ - 1) ? '0 : gnt_id + 1'b1;
        cnt <= '0;
      end
      if (state == RUN) begin
        result[cnt*8 +: 8] <= add_sum;
        carry <= add_cout;
        a_sh <= a_sh >> 8;
        b_sh <= b_sh >> 8;
        cnt <= cnt + 1'b1;
        if (last) cout_q <= add_cout;
`ifdef PFX_SCHED_OVF_EN
        if (last) ovf_q <= (a_sh[7] == b_sh[7]) && (add_sum[7] != a_sh[7]);
`endif
      end
    end
  end
endmodule
